// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/and/or/xor/slt) finish on the accept edge. mul and div
// are iterative and take WIDTH further cycles. Only one operation is in flight.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     operands/opcode valid      in_ready   block accepts an operation
//   a, b         WIDTH-bit operands         alu_control 3-bit opcode
//   out_valid    result/flags valid         out_ready  consumer accepts result
//   result       2*WIDTH registered result  alu_flags  registered {N,Z,C,V}
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           alu_control,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [3:0]           alu_flags
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a;     // multiplicand
  logic [WIDTH-1:0] op_b;     // divisor
  logic             op_div;   // 1: divide, 0: multiply
  logic [WIDTH-1:0] work_hi;  // mul: partial product high / div: partial remainder
  logic [WIDTH-1:0] work_lo;  // mul: multiplier bits    / div: dividend -> quotient
  logic [CW-1:0]    count;

  logic is_iter;
  assign is_iter = alu_control[2] & alu_control[1];

  // Single-cycle datapath works straight off the inputs; it is only used on the
  // accept edge, where the inputs are exactly what gets latched.
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [WIDTH-1:0] sc_low;
  logic             sc_c, sc_v;
  logic [3:0]       sc_flags;

  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} - {1'b0, b};
    sc_low  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (alu_control)
      3'b000: begin
        sc_low = add_ext[WIDTH-1:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_low[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        sc_low = sub_ext[WIDTH-1:0];
        sc_c   = ~sub_ext[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_low[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  sc_low = a & b;
      3'b011:  sc_low = a | b;
      3'b100:  sc_low = a ^ b;
      3'b101:  sc_low = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: sc_low = '0;
    endcase
    sc_flags = {sc_low[WIDTH-1], (sc_low == '0), sc_c, sc_v};
  end

  // One iteration step of shift-add multiply and restoring divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ok;
  logic [WIDTH-1:0]   div_hi_n, div_lo_n;
  logic [2*WIDTH-1:0] fin_result;
  logic [3:0]         fin_flags;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], work_lo[WIDTH-1:1]};

    // When the subtraction succeeds the true difference is below op_b, so the
    // low WIDTH bits of the wrapped subtraction are exact.
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, op_b});
    div_sub   = div_shift[WIDTH-1:0] - op_b;
    div_hi_n  = div_ok ? div_sub : div_shift[WIDTH-1:0];
    div_lo_n  = {work_lo[WIDTH-2:0], div_ok};

    // Divide by zero falls out naturally: every step succeeds, quotient is all
    // ones and the remainder ends up equal to the dividend.
    if (op_div) begin
      fin_result = {div_hi_n, div_lo_n};
      fin_flags  = {1'b0, (div_lo_n == '0), 1'b0, (op_b == '0)};
    end else begin
      fin_result = {mul_hi_n, mul_lo_n};
      fin_flags  = {mul_hi_n[WIDTH-1], ({mul_hi_n, mul_lo_n} == '0),
                    (mul_hi_n != '0), (mul_hi_n != '0)};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_iter ? BUSY : DONE;
      end
      BUSY: begin
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_div    <= 1'b0;
      work_hi   <= '0;
      work_lo   <= '0;
      count     <= '0;
      result    <= '0;
      alu_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= b;
            op_div  <= alu_control[0];
            work_hi <= '0;
            work_lo <= alu_control[0] ? a : b;
            if (is_iter) begin
              count <= CW'(WIDTH);
            end else begin
              result    <= {{WIDTH{1'b0}}, sc_low};
              alu_flags <= sc_flags;
            end
          end
        end
        BUSY: begin
          work_hi <= op_div ? div_hi_n : mul_hi_n;
          work_lo <= op_div ? div_lo_n : mul_lo_n;
          count   <= count - 1'b1;
          if (count == CW'(1)) begin
            result    <= fin_result;
            alu_flags <= fin_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
